// File: rtl/keypad_scan_buffer.sv
// keypad_scan_buffer: matrix keypad scanner with frame debounce, ghost rejection and a show-ahead event FIFO.
// Define KEYPAD_REPEAT_EN to build the auto-repeat counter.
module keypad_scan_buffer #(
  parameter int ROWS        = 4,
  parameter int COLS        = 4,
  parameter int SETTLE      = 1,
  parameter int DEBOUNCE    = 3,
  parameter int FIFO_DEPTH  = 4,
  parameter int REPEAT_DLY  = 8,
  parameter int REPEAT_RATE = 4,
  parameter int CW          = $clog2(ROWS*COLS),
  parameter int FW          = $clog2(FIFO_DEPTH)+1
) (
  input  logic            Clock,
  input  logic            reset,
  input  logic [ROWS-1:0] RowIn,
  output tri   [COLS-1:0] ColOut,
  input  logic            KeyRd,
  output logic            key_valid,
  output logic [CW-1:0]   key_code,
  output logic [FW-1:0]   fill,
  output logic            overflow,
  input  logic            ovf_clr
);
  localparam int N   = ROWS*COLS;
  localparam int PW  = FW-1;
  localparam int CLW = $clog2(COLS);
  typedef enum logic {DRIVE, EVAL} state_t;
  typedef enum logic [1:0] {NONE, SINGLE, MULTI} kind_t;
  if (ROWS < 2 || ROWS > 8 || COLS < 2 || COLS > 8 || SETTLE < 0 || SETTLE > 15 || DEBOUNCE < 1 ||
      DEBOUNCE > 15 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH-1)) != 0 || REPEAT_DLY < 1 || REPEAT_RATE < 1) begin : g_bad_params
    $error("keypad_scan_buffer: parameter out of range");
  end
  state_t         state;
  kind_t          kind, pkind;
  logic [CLW-1:0] col;
  logic [3:0]     cnt, stable, stable_nx;
  logic [N-1:0]   snap;
  logic [CW-1:0]  code, pcode;
  logic           any, many, same, eval, press, rep_fire, push, wr, pop, full, armed;
  logic [CW-1:0]  mem [FIFO_DEPTH];
  logic [PW-1:0]  rptr, wptr;
  for (genvar c = 0; c < COLS; c++) begin : g_col
    assign ColOut[c] = (!reset && state == DRIVE && col == CLW'(c)) ? 1'b0 : 1'bz;
  end
  always_comb begin
    any  = 1'b0;
    many = 1'b0;
    code = '0;
    for (int i = 0; i < N; i++)
      if (snap[i]) begin
        many = many | any;
        any  = 1'b1;
        code = CW'(i);
      end
    kind = many ? MULTI : any ? SINGLE : NONE;
  end
  assign same      = kind == pkind && (kind != SINGLE || code == pcode);
  assign stable_nx = !same ? 4'd1 : stable == 4'(DEBOUNCE) ? stable : stable + 4'd1;
  assign eval      = state == EVAL;
  assign press     = eval && kind == SINGLE && stable_nx == 4'(DEBOUNCE) && armed;
  always_ff @(posedge Clock)
    if (reset) begin
      state  <= DRIVE;
      col    <= '0;
      cnt    <= '0;
      snap   <= '0;
      stable <= '0;
      pkind  <= NONE;
      pcode  <= '0;
      armed  <= 1'b0;
    end else if (state == DRIVE) begin
      cnt <= cnt == 4'(SETTLE) ? 4'd0 : cnt + 4'd1;
      if (cnt == 4'(SETTLE)) begin
        snap[col*ROWS +: ROWS] <= ~RowIn;
        col <= col == CLW'(COLS-1) ? '0 : col + 1'b1;
        if (col == CLW'(COLS-1)) state <= EVAL;
      end
    end else begin
      state  <= DRIVE;
      stable <= stable_nx;
      pkind  <= kind;
      pcode  <= code;
      armed  <= press ? 1'b0 : (kind == NONE && stable_nx == 4'(DEBOUNCE)) ? 1'b1 : armed;
    end
`ifdef KEYPAD_REPEAT_EN
  localparam int RMAX = REPEAT_DLY > REPEAT_RATE ? REPEAT_DLY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX+1);
  logic [RW-1:0] rcnt;
  logic          rep_act;
  // rcnt counts frames down to the next repeat; reloaded at the press and after each repeat
  assign rep_fire = eval && rep_act && same && rcnt == RW'(1);
  always_ff @(posedge Clock)
    if (reset) begin
      rep_act <= 1'b0;
      rcnt    <= '0;
    end else if (eval) begin
      rep_act <= press | (rep_act & same);
      rcnt    <= press ? RW'(REPEAT_DLY) : rcnt == RW'(1) ? RW'(REPEAT_RATE) : rcnt - 1'b1;
    end
`else
  assign rep_fire = 1'b0;
`endif
  assign push      = press | rep_fire;
  assign key_valid = fill != '0;
  assign full      = fill == FW'(FIFO_DEPTH);
  assign pop       = KeyRd && key_valid;
  assign wr        = push && (!full || pop);
  assign key_code  = key_valid ? mem[rptr] : '0;
  always_ff @(posedge Clock)
    if (wr) mem[wptr] <= code;
  always_ff @(posedge Clock)
    if (reset) begin
      rptr     <= '0;
      wptr     <= '0;
      fill     <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      fill     <= fill + FW'(wr) - FW'(pop);
      overflow <= (push && !wr) | (overflow & ~ovf_clr);
    end
endmodule

// File: tb/tb_keypad_scan_buffer.sv
// tb_keypad_scan_buffer: randomized and directed frames against a frame-level event/FIFO model.
module tb_keypad_scan_buffer;
  localparam int R = 4, DB = 3, DEPTH = 4, DLY = 8, RATE = 4;
  logic       clk = 1'b0, rst = 1'b1, key_rd = 1'b0, clr = 1'b0;
  logic [3:0] row_in = '1;
  wire  [3:0] col_out;
  logic       key_valid, overflow;
  logic [3:0] key_code;
  logic [2:0] fill;
  int checks = 0, failures = 0;
  int mq[$];
  bit m_ovf = 0, armed = 0, rep_on = 0;
  int prev_cid = -1, run = 0, press_run = 0;
  always #5 clk = ~clk;
  keypad_scan_buffer dut (
    .Clock(clk), .reset(rst), .RowIn(row_in), .ColOut(col_out), .KeyRd(key_rd),
    .key_valid(key_valid), .key_code(key_code), .fill(fill), .overflow(overflow), .ovf_clr(clr)
  );
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic check_state(input string tag);
    check({tag, "_valid"}, int'(key_valid), mq.size() > 0 ? 1 : 0);
    check({tag, "_fill"}, int'(fill), mq.size());
    check({tag, "_ovf"}, int'(overflow), int'(m_ovf));
    if (mq.size() > 0) check({tag, "_code"}, int'(key_code), mq[0]);
  endtask
  task automatic reset_dut();
    rst = 1'b1;
    key_rd = 1'b0;
    clr = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", int'(key_valid), 0);
    check("rst_fill", int'(fill), 0);
    check("rst_ovf", int'(overflow), 0);
    check("rst_code", int'(key_code), 0);
    rst = 1'b0;
    mq.delete();
    m_ovf = 0; armed = 0; rep_on = 0; prev_cid = -1; run = 0;
  endtask
  // One scan frame: rows reflect the keys only in each column's capture cycle, junk elsewhere
  task automatic frame(input logic [15:0] keys, input int rd = -1, input int oc = -1);
    int cid, n, f;
    bit push;
    for (int i = 0; i < 9; i++) begin
      if (i == rd) begin
        check("pop_valid", int'(key_valid), mq.size() > 0 ? 1 : 0);
        if (mq.size() > 0) check("pop_code", int'(key_code), mq[0]);
      end
      key_rd = (i == rd);
      clr = (i == oc);
      row_in = (i < 8 && i % 2 == 1) ? ~keys[(i/2)*R +: R] : 4'($urandom);
      @(negedge clk);
    end
    key_rd = 1'b0;
    clr = 1'b0;
    row_in = '1;
    n = $countones(keys);
    cid = n == 0 ? -1 : -2;
    if (n == 1) for (int k = 0; k < 16; k++) if (keys[k]) cid = k;
    run = cid == prev_cid ? run + 1 : 1;
    prev_cid = cid;
    if (run == 1) rep_on = 0;
    push = 0;
    f = run - press_run;
    if (cid == -1 && run >= DB) armed = 1;
    if (cid >= 0 && run >= DB && armed) begin
      push = 1; armed = 0; rep_on = 1; press_run = run;
    end
`ifdef KEYPAD_REPEAT_EN
    else if (rep_on && (f == DLY || (f > DLY && (f - DLY) % RATE == 0))) push = 1;
`endif
    if (rd >= 0 && mq.size() > 0) void'(mq.pop_front());
    if (oc >= 0) m_ovf = 0;
    if (push) begin
      if (mq.size() < DEPTH) mq.push_back(cid);
      else m_ovf = 1;
    end
    check_state("frame");
  endtask
  task automatic tap(input int k);
    repeat (3) frame(16'h1 << k);
    repeat (3) frame(16'h0);
  endtask
  initial begin
    int codes[5] = '{0, 5, 10, 15, 3};
    int fills[4] = '{1, 2, 7, 8};
    reset_dut();
    repeat (3) frame(16'h0);
    repeat (5) frame(16'h0040);
    frame(16'h0, 2);
    repeat (2) frame(16'h0);
    repeat (5) frame(16'h0003);
    repeat (3) frame(16'h0);
    for (int i = 0; i < 6; i++) frame(i % 2 == 0 ? 16'h0040 : 16'h0000);
    repeat (3) frame(16'h0040);
    repeat (3) frame(16'h0, 4);
    foreach (codes[i]) tap(codes[i]);
    repeat (4) frame(16'h0, 5);
    frame(16'h0, -1, 3);
    foreach (fills[i]) tap(fills[i]);
    repeat (2) frame(16'h1000);
    frame(16'h1000, 8);
    repeat (3) frame(16'h0);
    repeat (4) frame(16'h0, 1);
    row_in = 4'h0;
    reset_dut();
    repeat (4) frame(16'h0040);
    repeat (3) frame(16'h0);
    repeat (3) frame(16'h0040);
    frame(16'h0, 0);
    repeat (2) frame(16'h0);
    repeat (20) frame(16'h0200, 0);
    repeat (3) frame(16'h0, 0);
    tap(4);
    tap(11);
    row_in = 4'h0;
    repeat (5) @(negedge clk);
    reset_dut();
    repeat (3) frame(16'h0);
    for (int it = 0; it < 40; it++) begin
      int sel, a, b, hold;
      logic [15:0] keys;
      sel = $urandom_range(0, 9);
      a = $urandom_range(0, 15);
      b = (a + $urandom_range(1, 15)) % 16;
      keys = sel < 4 ? 16'h0 : sel < 8 ? 16'h1 << a : (16'h1 << a) | (16'h1 << b);
      hold = $urandom_range(1, 5);
      for (int h = 0; h < hold; h++)
        frame(keys, $urandom_range(0, 3) == 0 ? $urandom_range(0, 8) : -1,
              $urandom_range(0, 7) == 0 ? $urandom_range(0, 8) : -1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
